// File: rtl/issue_sched_param.sv
// Instruction-issue scheduler: holds decoded ops on RAW/WAW scoreboard hazards and
// issues each one to a free ALU (round-robin), advint, memunit or branch unit.
module issue_sched_param #(
   parameter int NUM_ALU = 2,
   parameter int NUM_WB  = 2,
   parameter int RW      = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_type,
   input  logic [2:0]           in_unit,
   input  logic [RW-1:0]        in_r1,
   input  logic [RW-1:0]        in_r2,
   input  logic [RW-1:0]        in_rd,
   input  logic [RW-1:0]        in_rd2,
   input  logic [NUM_WB-1:0]    wb_valid,
   input  logic [NUM_WB*RW-1:0] wb_rn,
   input  logic [NUM_ALU-1:0]   alu_busy,
   input  logic                 advint_busy,
   input  logic                 memunit_busy,
   input  logic                 branch_busy,
   output logic [NUM_ALU-1:0]   alu_en,
   output logic                 advint_en,
   output logic                 memunit_en,
   output logic                 branch_en,
   output logic [RW-1:0]        rd_out_rn,
   output logic [RW-1:0]        rd2_out_rn,
   output logic                 illegal_op
);

   localparam int NREG = 1 << RW;
   localparam int PW   = (NUM_ALU > 1) ? $clog2(NUM_ALU) : 1;

   logic [NREG-1:0] sb_reg, sb_next;
   logic [NREG-1:0] fin_vec, busy_vec;
   logic [NREG-1:0] wb_hot [NUM_WB];
   logic            startup_reg;
   logic [PW-1:0]   rr_reg, rr_next;
   logic [PW-1:0]   pick_idx;
   logic            pick_ok;

   logic dec_alu, dec_adv, dec_mem, dec_br, dec_ill;
   logic hazard, unit_free, accept;

   // One-hot decode of each writeback port, OR-ed into the finishing set
   generate
      for (genvar gi = 0; gi < NUM_WB; gi++) begin : g_wb
         assign wb_hot[gi] = wb_valid[gi] ? (NREG'(1) << wb_rn[gi*RW +: RW]) : '0;
      end
   endgenerate

   always_comb begin
      fin_vec = '0;
      for (int i = 0; i < NUM_WB; i++) begin
         fin_vec = fin_vec | wb_hot[i];
      end
   end

   // A register finishing this cycle no longer blocks; register 0 never does
   assign busy_vec = sb_reg & ~fin_vec & ~NREG'(1);

   assign dec_alu = ~in_unit[2];
   assign dec_adv = ~in_type & (in_unit == 3'd4);
   assign dec_mem = in_type & ((in_unit == 3'd4) | (in_unit == 3'd5) | (in_unit == 3'd6));
   assign dec_br  = (in_unit == 3'd7);
   assign dec_ill = ~in_type & ((in_unit == 3'd5) | (in_unit == 3'd6));

   assign hazard = busy_vec[in_r1] | busy_vec[in_r2] | busy_vec[in_rd]
                 | (dec_adv & busy_vec[in_rd2]);

   assign unit_free = (dec_alu & ~(&alu_busy))
                    | (dec_adv & ~advint_busy)
                    | (dec_mem & ~memunit_busy)
                    | (dec_br  & ~branch_busy);

   assign in_ready = ~startup_reg & ~hazard & (dec_ill | unit_free);
   assign accept   = in_valid & in_ready;

   // First free ALU scanning upward from the round-robin pointer, with wrap
   always_comb begin
      int idx;
      idx      = 0;
      pick_idx = '0;
      pick_ok  = 1'b0;
      for (int k = 0; k < NUM_ALU; k++) begin
         idx = (int'(rr_reg) + k) % NUM_ALU;
         if (!pick_ok && !alu_busy[idx]) begin
            pick_ok  = 1'b1;
            pick_idx = PW'(idx);
         end
      end
   end

   assign rr_next = (int'(pick_idx) == NUM_ALU - 1) ? '0 : pick_idx + PW'(1);

   // Clears first, then sets, so a same-edge set wins
   always_comb begin
      sb_next = sb_reg & ~fin_vec;
      if (accept && !dec_ill) begin
         sb_next[in_rd] = 1'b1;
         if (dec_adv) begin
            sb_next[in_rd2] = 1'b1;
         end
      end
      sb_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         startup_reg <= 1'b1;
         sb_reg      <= '0;
         rr_reg      <= '0;
         alu_en      <= '0;
         advint_en   <= 1'b0;
         memunit_en  <= 1'b0;
         branch_en   <= 1'b0;
         rd_out_rn   <= '0;
         rd2_out_rn  <= '0;
         illegal_op  <= 1'b0;
      end else begin
         startup_reg <= 1'b0;
         sb_reg      <= sb_next;
         alu_en      <= (accept && dec_alu && pick_ok) ? (NUM_ALU'(1) << pick_idx) : '0;
         advint_en   <= accept & dec_adv;
         memunit_en  <= accept & dec_mem;
         branch_en   <= accept & dec_br;
         rd_out_rn   <= (accept && !dec_ill) ? in_rd : '0;
         rd2_out_rn  <= (accept && dec_adv) ? in_rd2 : '0;
         illegal_op  <= accept & dec_ill;
         if (accept && dec_alu) begin
            rr_reg <= rr_next;
         end
      end
   end

endmodule
